toggle_handshake_receiver: RTL and testbench
============================================

Name: toggle_handshake_receiver

Overview:
- Receiving end of the two-phase (toggle) handshake. The sender drives a toggle request generated by a T flip-flop and holds a data word stable alongside it.
- This block synchronises the request, captures the word into a one-entry buffer, and presents it downstream on a valid/ready interface.
- When downstream consumes the word, the block returns a toggled acknowledge.
- Sits at the consumer side of every toggle-signalled crossing or link in the design.

Parameters:
- DATA_W, 8, width of data_in/data_out.
- SYNC_STAGES, 2, flops in the req_tgl synchroniser chain (legal range 2..4).
- CNT_W, 8, width of the completed-transfer counter.

Ports:
- clk  input  1  rising-edge clock; sole clock of the block.
- rst  input  1  reset, synchronous, active-low: all state clears on a rising clk edge while rst=0.
- req_tgl  input  1  request from the sender; every level change is one transfer.
- data_in  input  DATA_W  sender data; stable from the req_tgl change until ack_tgl matches it.
- ack_tgl  output  1  acknowledge to the sender; registered.
- data_out  output  DATA_W  captured word; valid while out_valid=1.
- out_valid  output  1  buffer holds an unconsumed word.
- out_ready  input  1  downstream accepts data_out this cycle.
- xfer_count  output  CNT_W  number of completed transfers; wraps.
- overrun  output  1  sticky protocol-violation flag.

Behaviour:
- Reset (rst=0 at a clk edge):
  - Synchroniser chain, req_prev, ack_tgl, out_valid, xfer_count and overrun all go to 0.
  - data_out goes to 0. State goes to IDLE.
  - Reset mid-transfer discards the held word. The sender must be reset with the block.
- Synchroniser: req_tgl passes through SYNC_STAGES flops; the last stage is req_s. req_prev is a register holding the last consumed request level.
- Event: req_s != req_prev.
- State IDLE (out_valid=0):
  - On an event: capture data_out <= data_in, set req_prev <= req_s, set out_valid <= 1, go to HOLD.
  - Latency: out_valid rises on the (SYNC_STAGES+1)th rising edge after the first edge that samples the new req_tgl level. This is 3 edges at the default.
- State HOLD (out_valid=1):
  - data_out is held stable.
  - Release occurs when out_valid=1 and out_ready=1 at an edge. On release: out_valid <= 0, ack_tgl <= req_prev, xfer_count <= xfer_count+1 (mod 2^CNT_W), go to IDLE.
  - ack_tgl is set to req_prev rather than inverted. Normally the two are equivalent; this also realigns parity after an overrun.
  - out_ready while out_valid=0 has no effect.
- Overrun (an event while in HOLD; a legal sender never produces this):
  - overrun <= 1, sticky until reset.
  - Without a release the same cycle: req_prev <= req_s, the new word is dropped, and the buffer is not overwritten.
  - With a release the same cycle: release completes as above, req_prev is left unchanged, and the new word is captured on the following edge from IDLE.
- No combinational path from any input to any output.
- Throughput: at most one transfer per full round trip. A sender toggling req_tgl immediately on seeing ack_tgl change gets a transfer every ~2*(SYNC_STAGES+1) cycles plus the downstream stall.

Test Plan:
- Reset: hold rst=0 for 2 edges with req_tgl=1 -> ack_tgl=0, out_valid=0, xfer_count=0, overrun=0. Release rst -> a 0->1 transfer is seen, out_valid=1 three edges later.
- Single transfer, out_ready tied 1:
  - req_tgl 0->1 with data_in=8'hA5 -> out_valid=1, data_out=8'hA5 on the third edge.
  - Next edge: ack_tgl=1, out_valid=0, xfer_count=1.
- Downstream stall:
  - Transfer 8'h3C with out_ready=0 for 5 cycles -> out_valid and data_out=8'h3C held, ack_tgl unchanged.
  - out_ready=1 -> ack toggles one edge later, xfer_count increments.
- Back-to-back: sender modelled as a T flip-flop toggling req_tgl on each ack_tgl change, 300 words (incrementing data) -> all received in order, xfer_count=300 mod 256=44, overrun=0.
- Overrun: toggle req_tgl twice (8'h11 then 8'h22) while out_ready=0 -> overrun=1, data_out stays 8'h11. After release, ack_tgl equals req_tgl and no further out_valid occurs.
- Reset mid-HOLD: rst=0 while out_valid=1 -> next edge out_valid=0, ack_tgl=0, xfer_count=0, overrun=0.

Source files
------------

// File: rtl/toggle_handshake_receiver.sv
// Receiving end of a two-phase (toggle) handshake: synchronises the request,
// buffers one word for a valid/ready consumer and returns a toggled acknowledge.
module toggle_handshake_receiver #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int CNT_W       = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_tgl,
    input  logic [DATA_W-1:0] data_in,
    output logic              ack_tgl,
    output logic [DATA_W-1:0] data_out,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  xfer_count,
    output logic              overrun
);

    typedef enum logic {
        IDLE = 1'b0,
        HOLD = 1'b1
    } state_t;

    state_t                 state, state_n;
    logic [SYNC_STAGES-1:0] sync;
    logic                   req_s;
    logic                   req_prev, req_prev_n;
    logic                   ack_n;
    logic                   valid_n;
    logic                   overrun_n;
    logic [DATA_W-1:0]      data_n;
    logic [CNT_W-1:0]       count_n;
    logic                   req_event;
    logic                   release_now;

    assign req_s       = sync[SYNC_STAGES-1];
    assign req_event   = (req_s != req_prev);
    assign release_now = (state == HOLD) && out_ready;

    always_ff @(posedge clk) begin
        if (!rst) begin
            sync <= '0;
        end else begin
            sync <= {sync[SYNC_STAGES-2:0], req_tgl};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            req_prev   <= 1'b0;
            ack_tgl    <= 1'b0;
            out_valid  <= 1'b0;
            overrun    <= 1'b0;
            data_out   <= '0;
            xfer_count <= '0;
        end else begin
            state      <= state_n;
            req_prev   <= req_prev_n;
            ack_tgl    <= ack_n;
            out_valid  <= valid_n;
            overrun    <= overrun_n;
            data_out   <= data_n;
            xfer_count <= count_n;
        end
    end

    // An event in HOLD is an overrun; if the buffer drains on the same edge the
    // pending request is kept so it is captured from IDLE on the next edge.
    always_comb begin
        state_n    = state;
        req_prev_n = req_prev;
        ack_n      = ack_tgl;
        valid_n    = out_valid;
        overrun_n  = overrun;
        data_n     = data_out;
        count_n    = xfer_count;
        case (state)
            IDLE: begin
                if (req_event) begin
                    data_n     = data_in;
                    req_prev_n = req_s;
                    valid_n    = 1'b1;
                    state_n    = HOLD;
                end
            end
            HOLD: begin
                if (req_event) begin
                    overrun_n = 1'b1;
                    if (!release_now) begin
                        req_prev_n = req_s;
                    end
                end
                if (release_now) begin
                    valid_n = 1'b0;
                    ack_n   = req_prev;
                    count_n = xfer_count + CNT_W'(1);
                    state_n = IDLE;
                end
            end
            default: begin
                state_n = IDLE;
                valid_n = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_toggle_handshake_receiver.sv
// Self-checking bench: directed protocol steps plus a randomly stalled
// back-to-back run checked against a FIFO scoreboard.
module tb_toggle_handshake_receiver;

    logic       clk;
    logic       rst;
    logic       req_tgl;
    logic [7:0] data_in;
    logic       ack_tgl;
    logic [7:0] data_out;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] xfer_count;
    logic       overrun;

    int checks = 0;
    int errors = 0;

    toggle_handshake_receiver #(
        .DATA_W(8),
        .SYNC_STAGES(2),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .req_tgl(req_tgl),
        .data_in(data_in),
        .ack_tgl(ack_tgl),
        .data_out(data_out),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .xfer_count(xfer_count),
        .overrun(overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one rising edge and settle so outputs are sampled away from it.
    task automatic applyStimulus(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    logic [7:0] sent_q[$];
    logic [7:0] exp_word;
    int         sent;
    int         received;
    int         cycles;
    int         late_valid;
    int         exp_count;

    initial begin
        rst       = 1'b0;
        req_tgl   = 1'b1;
        data_in   = 8'h00;
        out_ready = 1'b1;

        // Reset with the request already high
        applyStimulus(2);
        checkOutput("rst_ack", ack_tgl, 0);
        checkOutput("rst_valid", out_valid, 0);
        checkOutput("rst_count", xfer_count, 0);
        checkOutput("rst_overrun", overrun, 0);

        // Leaving reset exposes the 0->1 request as a transfer of A5
        data_in = 8'hA5;
        rst     = 1'b1;
        applyStimulus(1);
        checkOutput("lat_edge1_valid", out_valid, 0);
        applyStimulus(1);
        checkOutput("lat_edge2_valid", out_valid, 0);
        applyStimulus(1);
        checkOutput("lat_edge3_valid", out_valid, 1);
        checkOutput("single_data", data_out, 8'hA5);
        applyStimulus(1);
        checkOutput("single_ack", ack_tgl, 1);
        checkOutput("single_valid_low", out_valid, 0);
        checkOutput("single_count", xfer_count, 1);

        // Downstream stall holds the word and the acknowledge
        out_ready = 1'b0;
        data_in   = 8'h3C;
        req_tgl   = 1'b0;
        applyStimulus(3);
        checkOutput("stall_valid", out_valid, 1);
        for (int i = 0; i < 5; i++) begin
            applyStimulus(1);
            checkOutput("stall_hold_valid", out_valid, 1);
            checkOutput("stall_hold_data", data_out, 8'h3C);
            checkOutput("stall_hold_ack", ack_tgl, 1);
        end
        out_ready = 1'b1;
        applyStimulus(1);
        checkOutput("stall_release_ack", ack_tgl, 0);
        checkOutput("stall_release_count", xfer_count, 2);
        checkOutput("stall_release_valid", out_valid, 0);

        // Fresh reset, then 300 back-to-back words with random stalls
        rst     = 1'b0;
        req_tgl = 1'b0;
        applyStimulus(2);
        rst       = 1'b1;
        sent      = 0;
        received  = 0;
        cycles    = 0;
        exp_count = 0;
        while (received < 300 && cycles < 20000) begin
            if (ack_tgl == req_tgl && sent < 300 && !out_valid) begin
                data_in = 8'(sent + 8'h40);
                sent_q.push_back(data_in);
                req_tgl = ~req_tgl;
                sent++;
            end
            out_ready = ($urandom_range(0, 3) != 0);
            if (out_valid && out_ready) begin
                exp_word = (sent_q.size() > 0) ? sent_q.pop_front() : 8'hxx;
                checkOutput("b2b_word", data_out, exp_word);
                received++;
                exp_count = (exp_count + 1) % 256;
            end
            applyStimulus(1);
            cycles++;
        end
        checkOutput("b2b_received", received, 300);
        checkOutput("b2b_count", xfer_count, 8'(exp_count));
        checkOutput("b2b_count_44", xfer_count, 44);
        checkOutput("b2b_overrun", overrun, 0);
        out_ready = 1'b0;
        applyStimulus(4);
        checkOutput("b2b_ack_match", ack_tgl, req_tgl);

        // Overrun: a second toggle while the first word is still held
        data_in = 8'h11;
        req_tgl = ~req_tgl;
        applyStimulus(3);
        checkOutput("ovr_first_valid", out_valid, 1);
        checkOutput("ovr_first_data", data_out, 8'h11);
        data_in = 8'h22;
        req_tgl = ~req_tgl;
        applyStimulus(4);
        checkOutput("ovr_flag", overrun, 1);
        checkOutput("ovr_data_kept", data_out, 8'h11);
        checkOutput("ovr_still_valid", out_valid, 1);
        out_ready = 1'b1;
        applyStimulus(1);
        checkOutput("ovr_release_valid", out_valid, 0);
        checkOutput("ovr_ack_realign", ack_tgl, req_tgl);
        late_valid = 0;
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1);
            if (out_valid) late_valid++;
        end
        checkOutput("ovr_no_more_valid", late_valid, 0);
        checkOutput("ovr_sticky", overrun, 1);

        // Reset while a word is held
        out_ready = 1'b0;
        req_tgl   = ~req_tgl;
        data_in   = 8'h5A;
        applyStimulus(3);
        checkOutput("midhold_valid", out_valid, 1);
        rst     = 1'b0;
        req_tgl = 1'b0;
        applyStimulus(1);
        checkOutput("midhold_rst_valid", out_valid, 0);
        checkOutput("midhold_rst_ack", ack_tgl, 0);
        checkOutput("midhold_rst_count", xfer_count, 0);
        checkOutput("midhold_rst_overrun", overrun, 0);
        checkOutput("midhold_rst_data", data_out, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
